// File: rtl/minc_dbg_pkg.sv
// minc_dbg_pkg: command opcodes and controller state encoding shared by the minc run controller
package minc_dbg_pkg;
   localparam logic [1:0] CMD_HALT   = 2'd0;
   localparam logic [1:0] CMD_RUN    = 2'd1;
   localparam logic [1:0] CMD_STEP   = 2'd2;
   localparam logic [1:0] CMD_SET_BP = 2'd3;
   typedef enum logic [1:0] {
      ST_HALTED   = 2'd0,
      ST_RUNNING  = 2'd1,
      ST_STEPPING = 2'd2
   } run_state_e;
endpackage

// File: rtl/minc_sat_counter.sv
// minc_sat_counter: counts enabled cycles and holds at all-ones; ports clk, rst (sync high), en, q
module minc_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] q
);
   always_ff @(posedge clk)
      if (rst) q <= '0;
      else if (en && q != '1) q <= q + W'(1);
endmodule

// File: rtl/minc_run_ctrl.sv
// minc_run_ctrl: run/step/breakpoint sequencer gating the minc core execute enable
// ports: CLK, RESET (sync high), cmd_valid/cmd_ready/cmd_op/cmd_arg command port,
//        pc_in core PC, cpu_en execute enable, halted, bp_hit pulse, cyc_cnt executed cycles
// MINC_RUN_CTRL_CYCCNT_EN: when defined cyc_cnt counts enabled cycles, otherwise it reads 0
module minc_run_ctrl
   import minc_dbg_pkg::*;
#(
   parameter int  PC_W   = 8,
   parameter int  STEP_W = 8,
   parameter int  CNT_W  = 16,
   localparam int ARG_W  = (PC_W > STEP_W) ? PC_W : STEP_W
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [ARG_W-1:0] cmd_arg,
   input  logic [PC_W-1:0]  pc_in,
   output logic             cpu_en,
   output logic             halted,
   output logic             bp_hit,
   output logic [CNT_W-1:0] cyc_cnt
);
   run_state_e        state, state_n;
   logic [PC_W-1:0]   bp_addr, bp_addr_n;
   logic [STEP_W-1:0] step_left, step_left_n, step_arg;
   logic              bp_en, bp_en_n, skip_bp, skip_bp_n, bp_match, take;
   assign step_arg  = cmd_arg[STEP_W-1:0];
   assign cmd_ready = (state != ST_STEPPING) || (cmd_op == CMD_HALT);
   assign take      = cmd_valid && cmd_ready;
   // skip_bp lets a RUN issued while parked on the breakpoint execute that instruction once
   assign bp_match  = bp_en && (pc_in == bp_addr) && !skip_bp;
   assign cpu_en    = (state == ST_RUNNING) ? !bp_match : (state == ST_STEPPING) && (step_left != '0);
   assign halted    = state == ST_HALTED;
   always_ff @(posedge CLK)
      if (RESET) begin
         state     <= ST_HALTED;
         bp_addr   <= '0;
         bp_en     <= 1'b0;
         step_left <= '0;
         skip_bp   <= 1'b0;
         bp_hit    <= 1'b0;
      end else begin
         state     <= state_n;
         bp_addr   <= bp_addr_n;
         bp_en     <= bp_en_n;
         step_left <= step_left_n;
         skip_bp   <= skip_bp_n;
         bp_hit    <= (state == ST_RUNNING) && bp_match;
      end
   always_comb begin
      state_n     = state;
      step_left_n = step_left;
      skip_bp_n   = skip_bp;
      bp_en_n     = bp_en || (take && cmd_op == CMD_SET_BP);
      bp_addr_n   = (take && cmd_op == CMD_SET_BP) ? cmd_arg[PC_W-1:0] : bp_addr;
      case (state)
         ST_HALTED: begin
            if (take && cmd_op == CMD_RUN) begin
               state_n   = ST_RUNNING;
               skip_bp_n = 1'b1;
            end else if (take && cmd_op == CMD_STEP && step_arg != '0) begin
               state_n     = ST_STEPPING;
               step_left_n = step_arg;
            end
         end
         ST_RUNNING: begin
            // a breakpoint wins over any command accepted in the same cycle
            if (bp_match) state_n = ST_HALTED;
            else begin
               skip_bp_n = 1'b0;
               if (take && cmd_op == CMD_HALT) state_n = ST_HALTED;
               else if (take && cmd_op == CMD_STEP) begin
                  state_n     = (step_arg != '0) ? ST_STEPPING : ST_HALTED;
                  step_left_n = step_arg;
               end
            end
         end
         ST_STEPPING: begin
            step_left_n = (take && cmd_op == CMD_HALT) ? '0 : step_left - STEP_W'(step_left != '0);
            state_n     = ((take && cmd_op == CMD_HALT) || step_left <= STEP_W'(1)) ? ST_HALTED : ST_STEPPING;
         end
         default: state_n = ST_HALTED;
      endcase
   end
`ifdef MINC_RUN_CTRL_CYCCNT_EN
   minc_sat_counter #(.W(CNT_W)) u_cnt (.clk(CLK), .rst(RESET), .en(cpu_en), .q(cyc_cnt));
`else
   assign cyc_cnt = '0;
`endif
endmodule

// File: tb/tb_minc_run_ctrl.sv
// tb_minc_run_ctrl: scoreboard bench for minc_run_ctrl with directed scenarios and random commands
module tb_minc_run_ctrl;
   localparam int HLT = 0, RUN = 1, STP = 2;
`ifdef MINC_RUN_CTRL_CYCCNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif
   logic        CLK = 1'b0, RESET, cmd_valid, cmd_ready, cpu_en, halted, bp_hit;
   logic [1:0]  cmd_op;
   logic [7:0]  cmd_arg, pc_in;
   logic [15:0] cyc_cnt;
   always #5 CLK = ~CLK;
   minc_run_ctrl dut (
      .CLK(CLK), .RESET(RESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_arg(cmd_arg), .pc_in(pc_in), .cpu_en(cpu_en),
      .halted(halted), .bp_hit(bp_hit), .cyc_cnt(cyc_cnt)
   );
   typedef struct {logic en; logic rdy; logic hlt; logic hit; logic [15:0] cnt;} exp_t;
   exp_t q[$];
   int checks = 0, errors = 0, en_seen = 0, hit_seen = 0;
   int mode, bp, left, cnt, pc;
   bit bpon, skip, hit, live;
   task automatic chk(input string n, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", n, got, exp, $time);
      end
   endtask
   always @(negedge CLK)
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("cpu_en", 16'(cpu_en), 16'(e.en));
         chk("cmd_ready", 16'(cmd_ready), 16'(e.rdy));
         chk("halted", 16'(halted), 16'(e.hlt));
         chk("bp_hit", 16'(bp_hit), 16'(e.hit));
         chk("cyc_cnt", cyc_cnt, e.cnt);
         if (cpu_en === 1'b1) en_seen++;
         if (bp_hit === 1'b1) hit_seen++;
      end
   // one clock of stimulus; the reference model predicts this cycle's outputs, then advances
   task automatic step(input bit v, input int op, input int arg, input bit r);
      bit match, en, rdy, acc;
      exp_t e;
      cmd_valid = v;
      cmd_op    = op[1:0];
      cmd_arg   = arg[7:0];
      RESET     = r;
      pc_in     = pc[7:0];
      match = bpon && pc == bp && !skip;
      en    = (mode == RUN && !match) || (mode == STP && left > 0);
      rdy   = mode != STP || op == 0;
      e = '{en, rdy, mode == HLT, hit, CNT_ON ? cnt[15:0] : 16'd0};
      if (live) q.push_back(e);
      @(posedge CLK);
      acc = v && rdy;
      if (en) pc = (pc + 1) % 256;
      if (r) begin
         mode = HLT; bp = 0; bpon = 0; left = 0; skip = 0; hit = 0; cnt = 0; live = 1;
      end else begin
         hit = mode == RUN && match;
         if (en && cnt < 65535) cnt++;
         if (acc && op == 3) begin bp = arg % 256; bpon = 1; end
         if (mode == HLT) begin
            if (acc && op == 1) begin mode = RUN; skip = 1; end
            else if (acc && op == 2 && arg % 256 != 0) begin mode = STP; left = arg % 256; end
         end else if (mode == RUN) begin
            if (match) mode = HLT;
            else begin
               skip = 0;
               if (acc && op == 0) mode = HLT;
               else if (acc && op == 2) begin left = arg % 256; mode = (left != 0) ? STP : HLT; end
            end
         end else if (acc && op == 0) begin
            mode = HLT; left = 0;
         end else begin
            left--;
            if (left == 0) mode = HLT;
         end
      end
      #1;
   endtask
   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0);
   endtask
   initial begin
      live = 0; pc = 0; mode = HLT;
      step(0, 0, 0, 1);
      idle(10);
      en_seen = 0;
      step(1, 2, 3, 0);
      repeat (3) step(1, 1, 0, 0);
      idle(3);
      chk("step3_en_cycles", 16'(en_seen), 16'd3);
      chk("step3_cnt", cyc_cnt, CNT_ON ? 16'd3 : 16'd0);
      step(1, 3, 5, 0);
      pc = 0; en_seen = 0; hit_seen = 0;
      step(1, 1, 0, 0);
      idle(10);
      chk("bp_en_cycles", 16'(en_seen), 16'd5);
      chk("bp_hit_pulses", 16'(hit_seen), 16'd1);
      chk("bp_halted", 16'(halted), 16'd1);
      en_seen = 0; hit_seen = 0;
      step(1, 1, 0, 0);
      idle(300);
      chk("rerun_en_cycles", 16'(en_seen), 16'd256);
      chk("rerun_hits", 16'(hit_seen), 16'd1);
      en_seen = 0;
      step(1, 2, 200, 0);
      idle(4);
      step(1, 0, 0, 0);
      idle(3);
      chk("step200_halt_cycles", 16'(en_seen), 16'd5);
      en_seen = 0;
      step(1, 2, 0, 0);
      idle(3);
      chk("step0_cycles", 16'(en_seen), 16'd0);
      pc = 0;
      step(1, 1, 0, 0);
      idle(3);
      step(0, 0, 0, 1);
      pc = 5; en_seen = 0; hit_seen = 0;
      step(1, 1, 0, 0);
      idle(10);
      chk("post_reset_en_cycles", 16'(en_seen), 16'd10);
      chk("post_reset_hits", 16'(hit_seen), 16'd0);
      step(1, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         int op, arg;
         op  = $urandom_range(0, 3);
         arg = (op == 2) ? $urandom_range(0, 12) : $urandom_range(0, 15);
         if ($urandom_range(0, 19) == 0) pc = $urandom_range(0, 15);
         step($urandom_range(0, 2) == 0, op, arg, $urandom_range(0, 199) == 0);
      end
      idle(2);
      chk("queue_drained", 16'(q.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/minc_run_ctrl.md
Name: minc_run_ctrl

Overview:
Run/debug sequencer for the minc core. Gates the core's per-cycle execute enable and accepts HALT/RUN/STEP/SET_BP commands over a valid/ready port. Stops the core at a PC breakpoint and counts executed cycles. Sits between the top-level/debug host and the minc datapath, which advances only in cycles where cpu_en=1.

Parameters:
PC_W, 8, width of program counter compare and breakpoint register
STEP_W, 8, width of STEP cycle-count argument
CNT_W, 16, width of executed-cycle counter

Ports:
CLK  in  1  single clock, all state on rising edge
RESET  in  1  synchronous, active-high; sampled on rising CLK
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at rising CLK
cmd_op  in  2  0=HALT, 1=RUN, 2=STEP, 3=SET_BP
cmd_arg  in  max(PC_W,STEP_W)  STEP count (low STEP_W bits) or breakpoint address (low PC_W bits)
pc_in  in  PC_W  core's current PC (address of next instruction to execute)
cpu_en  out  1  core executes one instruction-cycle when high
halted  out  1  state==HALTED
bp_hit  out  1  one-cycle pulse: run stopped by breakpoint
cyc_cnt  out  CNT_W  executed-cycle counter (see Optional Feature)

Behaviour:
- States: HALTED, RUNNING, STEPPING. State, bp_addr, bp_en, step_left, skip_bp, bp_hit, cyc_cnt are registers.
- Reset: state=HALTED, bp_addr=0, bp_en=0, step_left=0, skip_bp=0, bp_hit=0, cyc_cnt=0; outputs: cpu_en=0, halted=1, cmd_ready=1. Reset overrides any command or in-progress step that cycle.
- cmd_ready = (state!=STEPPING) | (cmd_op==HALT). HALT is always accepted; other ops stall during STEPPING.
- bp_match = bp_en & (pc_in==bp_addr) & ~skip_bp (combinational).
- cpu_en (combinational): RUNNING & ~bp_match, or STEPPING (step_left!=0; breakpoints ignored while stepping). HALTED -> 0.
- HALTED: RUN -> RUNNING, skip_bp=1. STEP with arg N!=0 -> STEPPING, step_left=N. STEP with N=0 -> accepted, no state change. SET_BP -> bp_addr=arg, bp_en=1. HALT -> no-op.
- RUNNING: bp_match -> HALTED, bp_hit=1 next cycle; the core does not execute the matching instruction. Otherwise: skip_bp cleared after the first cpu_en=1 cycle. HALT accepted -> HALTED next cycle; the core still executes in the cycle of acceptance if cpu_en=1. SET_BP updates bp_addr/bp_en and is visible next cycle. RUN -> no-op. STEP -> RUNNING->STEPPING with step_left=N; N=0 -> HALTED.
- STEPPING: each cycle cpu_en=1, step_left decrements; leaving after step_left goes 1->0 -> HALTED. Exactly N enabled cycles for STEP N. HALT accepted -> HALTED next cycle, step_left=0.
- Simultaneous bp_match and accepted HALT in RUNNING: HALTED, bp_hit=1 (breakpoint reported).
- bp_hit: high exactly one cycle, otherwise 0.
- Resuming with RUN while pc_in==bp_addr executes that instruction once (skip_bp), then rearms.
- Widths: cmd_arg low bits used; step_left is STEP_W bits, no wrap.

Optional Feature:
MINC_RUN_CTRL_CYCCNT_EN. Defined: cyc_cnt increments by 1 on every cycle with cpu_en=1, saturates at all-ones, cleared only by RESET. Undefined: no counter register; cyc_cnt tied to 0.

Decomposition:
- Package minc_dbg_pkg: cmd_op encodings (CMD_HALT=0, CMD_RUN=1, CMD_STEP=2, CMD_SET_BP=3) and state encoding constants.
- One natural sub-module: minc_sat_counter (width-parameterised enable/saturate counter) used for cyc_cnt.

Test Plan:
- Reset then idle 10 cycles -> halted=1, cpu_en=0, cmd_ready=1, cyc_cnt=0, bp_hit=0.
- STEP arg=3 from HALTED -> cpu_en high exactly 3 cycles, cmd_ready=0 for RUN during them, then halted=1; cyc_cnt=3 with macro, 0 without.
- SET_BP 0x05, RUN, model pc_in incrementing while cpu_en=1 from 0 -> cpu_en low at pc_in=5, bp_hit one pulse, halted=1, 5 enabled cycles.
- From that stop, RUN -> instruction at 0x05 executes, core continues; pc_in wraps to 0x05 again -> stops again with bp_hit.
- STEP arg=200, HALT after 4 cycles -> HALTED next cycle, total 5 enabled cycles; STEP arg=0 -> no enabled cycle.
- RESET asserted mid-RUN with bp set -> next cycle halted=1, cpu_en=0, bp_en cleared (RUN at 0x05 no longer stops there).
